// File: rtl/tl_rx_vc_pkg.sv
// Shared constants and buffer-type definitions for the RX virtual-channel data stores.
// One data store is instanced per posted, non-posted and completion queue.
package tl_rx_vc_pkg;

  localparam int DW_W      = 32;
  localparam int CREDIT_DW = 4;

  typedef enum logic [1:0] {
    BUF_P,
    BUF_NP,
    BUF_CPL
  } buf_type_e;

  localparam int DEPTH_P   = 256;
  localparam int DEPTH_NP  = 64;
  localparam int DEPTH_CPL = 256;

  function automatic int default_depth(input buf_type_e t);
    case (t)
      BUF_P:   return DEPTH_P;
      BUF_NP:  return DEPTH_NP;
      default: return DEPTH_CPL;
    endcase
  endfunction

endpackage

// File: rtl/tl_rx_vc_beat_aligner.sv
// Combinational read-beat aligner: shifts the entry window left by a DW offset and keeps
// the top BEAT_ENTRIES entries' worth of DWs. Single-entry mode passes the head entry.
module tl_rx_vc_beat_aligner #(
  parameter int LANES        = 8,
  parameter int BEAT_ENTRIES = 4,
  parameter int DW           = 32
) (
  input  logic [(BEAT_ENTRIES+1)*LANES*DW-1:0] window,
  input  logic [$clog2(LANES)-1:0]             dw_offset,
  output logic [BEAT_ENTRIES*LANES*DW-1:0]     beat
);

  localparam int WIN_W = (BEAT_ENTRIES + 1) * LANES * DW;
  localparam int OUT_W = BEAT_ENTRIES * LANES * DW;

  generate
    if (BEAT_ENTRIES == 1) begin : g_single
      logic unused_inputs;
      assign beat          = window[WIN_W-1 -: OUT_W];
      assign unused_inputs = ^{dw_offset, window[WIN_W-OUT_W-1:0]};
    end else begin : g_shift
      logic [WIN_W-1:0] shifted;
      logic             unused_tail;
      assign shifted     = window << (dw_offset * DW);
      assign beat        = shifted[WIN_W-1 -: OUT_W];
      assign unused_tail = ^shifted[WIN_W-OUT_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/tl_rx_vc_data_store.sv
// RX VC TLP data store: speculative writes with commit/abort, overflow/underflow flags,
// DW-offset read window and data-credit return on read release.
module tl_rx_vc_data_store
  import tl_rx_vc_pkg::*;
#(
  parameter int DW           = DW_W,
  parameter int LANES        = 8,
  parameter int DEPTH        = 256,
  parameter int BEAT_ENTRIES = 4,
  parameter int PTR_W        = $clog2(DEPTH) + 1,
  parameter int CR_W         = $clog2(DEPTH * LANES / CREDIT_DW) + 1,
  localparam int INC_W       = $clog2(BEAT_ENTRIES + 1) + 1,
  localparam int OFF_W       = $clog2(LANES)
) (
  input  logic                             i_clk,
  input  logic                             i_n_rst,
  input  logic                             i_w_en,
  input  logic [LANES*DW-1:0]              i_w_data,
  input  logic                             i_w_commit,
  input  logic                             i_w_commit_excl,
  input  logic                             i_w_abort,
  input  logic                             i_r_inc_en,
  input  logic [INC_W-1:0]                 i_r_inc_value,
  input  logic [OFF_W-1:0]                 i_r_dw_offset,
  input  logic                             i_err_clr,
  output logic [BEAT_ENTRIES*LANES*DW-1:0] o_r_data,
  output logic [PTR_W-1:0]                 o_r_ptr,
  output logic [PTR_W-1:0]                 o_w_ptr,
  output logic [PTR_W-1:0]                 o_used,
  output logic                             o_full,
  output logic                             o_empty,
  output logic                             o_overflow,
  output logic                             o_underflow,
  output logic                             o_cr_valid,
  output logic [CR_W-1:0]                  o_cr_data
);

  localparam int AW      = PTR_W - 1;
  localparam int ENTRY_W = LANES * DW;
  localparam int WIN_W   = (BEAT_ENTRIES + 1) * ENTRY_W;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   w_cntr, w_ptr, r_ptr;
  logic [PTR_W-1:0]   spec_used, used;
  logic               full, wr_ok, rd_ok;
  logic [WIN_W-1:0]   window;

  // Fullness uses the speculative counter so uncommitted entries are never overwritten.
  assign spec_used = w_cntr - r_ptr;
  assign used      = w_ptr - r_ptr;
  assign full      = (spec_used == PTR_W'(DEPTH));
  assign wr_ok     = i_w_en && !full;
  assign rd_ok     = i_r_inc_en && (PTR_W'(i_r_inc_value) <= used);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      w_cntr      <= '0;
      w_ptr       <= '0;
      r_ptr       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      o_cr_valid  <= 1'b0;
      o_cr_data   <= '0;
    end else begin
      if (i_w_abort) begin
        w_cntr <= w_ptr;
      end else begin
        if (wr_ok)      w_cntr <= w_cntr + PTR_W'(1);
        if (i_w_commit) w_ptr  <= w_cntr + PTR_W'(wr_ok && !i_w_commit_excl);
      end

      if (rd_ok) r_ptr <= r_ptr + PTR_W'(i_r_inc_value);
      o_cr_valid <= rd_ok && (i_r_inc_value != '0);
      o_cr_data  <= rd_ok ? CR_W'(i_r_inc_value) * CR_W'(LANES / CREDIT_DW) : '0;

      if (i_w_en && full)      o_overflow <= 1'b1;
      else if (i_err_clr)      o_overflow <= 1'b0;
      if (i_r_inc_en && !rd_ok) o_underflow <= 1'b1;
      else if (i_err_clr)       o_underflow <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately left without reset; the pointers alone
  // decide which entries are valid, and this lets the array map onto RAM.
  always_ff @(posedge i_clk) begin
    if (wr_ok && !i_w_abort) mem[w_cntr[AW-1:0]] <= i_w_data;
  end

  // NOTE: give every always_comb output a default before the loop so no latch is inferred.
  always_comb begin
    window = '0;
    for (int k = 0; k <= BEAT_ENTRIES; k++) begin
      window[(BEAT_ENTRIES-k)*ENTRY_W +: ENTRY_W] = mem[AW'(r_ptr + PTR_W'(k))];
    end
  end

  tl_rx_vc_beat_aligner #(
    .LANES       (LANES),
    .BEAT_ENTRIES(BEAT_ENTRIES),
    .DW          (DW)
  ) u_beat_aligner (
    .window   (window),
    .dw_offset(i_r_dw_offset),
    .beat     (o_r_data)
  );

  assign o_r_ptr = r_ptr;
  assign o_w_ptr = w_ptr;
  assign o_used  = used;
  assign o_full  = full;
  assign o_empty = (used == '0);

endmodule

// File: tb/tb_tl_rx_vc_data_store.sv
// Directed bench for tl_rx_vc_data_store: commit/abort/exclude, full/overflow, underflow,
// credit return, wrapped DW-offset read window and mid-TLP reset.
module tb_tl_rx_vc_data_store;

  localparam int DW      = 32;
  localparam int LANES   = 8;
  localparam int DEPTH   = 256;
  localparam int BE      = 4;
  localparam int PTR_W   = 9;
  localparam int CR_W    = 10;
  localparam int INC_W   = $clog2(BE + 1) + 1;
  localparam int OFF_W   = $clog2(LANES);
  localparam int ENTRY_W = LANES * DW;
  localparam int OUT_W   = BE * ENTRY_W;

  logic                 i_clk = 1'b0;
  logic                 i_n_rst;
  logic                 i_w_en, i_w_commit, i_w_commit_excl, i_w_abort;
  logic [ENTRY_W-1:0]   i_w_data;
  logic                 i_r_inc_en, i_err_clr;
  logic [INC_W-1:0]     i_r_inc_value;
  logic [OFF_W-1:0]     i_r_dw_offset;
  logic [OUT_W-1:0]     o_r_data;
  logic [PTR_W-1:0]     o_r_ptr, o_w_ptr, o_used;
  logic                 o_full, o_empty, o_overflow, o_underflow, o_cr_valid;
  logic [CR_W-1:0]      o_cr_data;

  int n_tests = 0;
  int n_fail  = 0;

  tl_rx_vc_data_store #(
    .DW(DW), .LANES(LANES), .DEPTH(DEPTH), .BEAT_ENTRIES(BE)
  ) dut (
    .i_clk(i_clk), .i_n_rst(i_n_rst),
    .i_w_en(i_w_en), .i_w_data(i_w_data), .i_w_commit(i_w_commit),
    .i_w_commit_excl(i_w_commit_excl), .i_w_abort(i_w_abort),
    .i_r_inc_en(i_r_inc_en), .i_r_inc_value(i_r_inc_value),
    .i_r_dw_offset(i_r_dw_offset), .i_err_clr(i_err_clr),
    .o_r_data(o_r_data), .o_r_ptr(o_r_ptr), .o_w_ptr(o_w_ptr), .o_used(o_used),
    .o_full(o_full), .o_empty(o_empty), .o_overflow(o_overflow),
    .o_underflow(o_underflow), .o_cr_valid(o_cr_valid), .o_cr_data(o_cr_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [ENTRY_W-1:0] d, input logic commit, input logic excl);
    i_w_en = 1'b1; i_w_data = d; i_w_commit = commit; i_w_commit_excl = excl;
    tick();
    i_w_en = 1'b0; i_w_commit = 1'b0; i_w_commit_excl = 1'b0;
  endtask

  task automatic rd(input int n);
    i_r_inc_en = 1'b1; i_r_inc_value = INC_W'(n);
    tick();
    i_r_inc_en = 1'b0; i_r_inc_value = '0;
  endtask

  // Entry whose DW j (j=0 in the MSBs) equals base + j.
  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [31:0] base);
    logic [ENTRY_W-1:0] e;
    e = '0;
    for (int j = 0; j < LANES; j++) e[ENTRY_W-1-32*j -: 32] = base + 32'(j);
    return e;
  endfunction

  // Addresses 254,255,0,1,2 carry DW values 0..39 in order; others carry a tagged pattern.
  function automatic logic [ENTRY_W-1:0] fill_entry(input int a);
    int idx;
    idx = (a - 254 + DEPTH) % DEPTH;
    if (idx < 5) return mk_entry(32'(idx * LANES));
    return mk_entry(32'hA000_0000 + 32'(a * 256));
  endfunction

  function automatic logic [31:0] beat_dw(input int k);
    return o_r_data[OUT_W-1-32*k -: 32];
  endfunction

  initial begin
    i_n_rst = 1'b0;
    i_w_en = 0; i_w_data = '0; i_w_commit = 0; i_w_commit_excl = 0; i_w_abort = 0;
    i_r_inc_en = 0; i_r_inc_value = '0; i_r_dw_offset = '0; i_err_clr = 0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_r_ptr", o_r_ptr, 0);
    check("rst_w_ptr", o_w_ptr, 0);
    check("rst_used", o_used, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_unf", o_underflow, 0);
    check("rst_cr_valid", o_cr_valid, 0);
    check("rst_cr_data", o_cr_data, 0);
    i_n_rst = 1'b1;
    tick();

    // Four writes, commit on the fourth (write included).
    for (int i = 0; i < 3; i++) wr(mk_entry(32'hC000_0000 + 32'(i * 16)), 1'b0, 1'b0);
    check("uncommitted_used", o_used, 0);
    wr(mk_entry(32'hC000_0030), 1'b1, 1'b0);
    check("commit_w_ptr", o_w_ptr, 4);
    check("commit_used", o_used, 4);
    check("commit_empty", o_empty, 0);
    check("head_off0", beat_dw(0), 32'hC000_0000);
    check("entry1_off0", beat_dw(8), 32'hC000_0010);
    i_r_dw_offset = 3'd1;
    #1;
    check("head_off1", beat_dw(0), 32'hC000_0001);
    check("head_off1_last", beat_dw(7), 32'hC000_0010);
    i_r_dw_offset = '0;
    rd(4);
    check("read4_r_ptr", o_r_ptr, 4);
    check("read4_empty", o_empty, 1);
    check("read4_cr_valid", o_cr_valid, 1);
    check("read4_cr_data", o_cr_data, 8);
    tick();
    check("cr_pulse_end", o_cr_valid, 0);

    // Abort discards three speculative writes; two new writes then commit.
    for (int i = 0; i < 3; i++) wr(mk_entry(32'hDEAD_0000 + 32'(i * 16)), 1'b0, 1'b0);
    i_w_abort = 1'b1; tick(); i_w_abort = 1'b0;
    check("abort_w_ptr", o_w_ptr, 4);
    check("abort_used", o_used, 0);
    wr(mk_entry(32'hB000_0000), 1'b0, 1'b0);
    wr(mk_entry(32'hB000_0010), 1'b0, 1'b0);
    i_w_commit = 1'b1; tick(); i_w_commit = 1'b0;
    check("post_abort_w_ptr", o_w_ptr, 6);
    check("post_abort_used", o_used, 2);
    for (int j = 0; j < LANES; j++)
      check($sformatf("post_abort_dw%0d", j), beat_dw(j), 32'hB000_0000 + 32'(j));
    check("post_abort_e1", beat_dw(8), 32'hB000_0010);

    // Commit excluding the same-cycle write, then a plain commit picks it up.
    wr(mk_entry(32'hE000_0000), 1'b1, 1'b1);
    check("excl_w_ptr", o_w_ptr, 6);
    i_w_commit = 1'b1; tick(); i_w_commit = 1'b0;
    check("late_commit_w_ptr", o_w_ptr, 7);
    i_w_abort = 1'b1; tick(); i_w_abort = 1'b0;
    check("noop_abort_w_ptr", o_w_ptr, 7);
    check("noop_abort_used", o_used, 3);

    // Underflow: used=3, request 4.
    rd(4);
    check("unf_r_ptr", o_r_ptr, 4);
    check("unf_flag", o_underflow, 1);
    check("unf_no_cr", o_cr_valid, 0);
    rd(0);
    check("inc0_no_cr", o_cr_valid, 0);
    check("inc0_r_ptr", o_r_ptr, 4);
    i_err_clr = 1'b1; tick(); i_err_clr = 1'b0;
    check("unf_clr", o_underflow, 0);
    rd(3);
    check("exact_read_r_ptr", o_r_ptr, 7);
    check("exact_read_cr", o_cr_data, 6);
    check("exact_read_empty", o_empty, 1);

    // Fill all 256 entries starting at address 7, commit on the last.
    for (int k = 0; k < DEPTH - 1; k++) wr(fill_entry((7 + k) % DEPTH), 1'b0, 1'b0);
    check("pre_full", o_full, 0);
    wr(fill_entry(6), 1'b1, 1'b0);
    check("full_flag", o_full, 1);
    check("full_w_ptr", o_w_ptr, 263);
    check("full_used", o_used, 256);
    wr(mk_entry(32'hFFFF_0000), 1'b1, 1'b0);
    check("ovf_flag", o_overflow, 1);
    check("ovf_w_ptr", o_w_ptr, 263);
    check("ovf_still_full", o_full, 1);
    i_err_clr = 1'b1; tick(); i_err_clr = 1'b0;
    check("ovf_clr", o_overflow, 0);
    i_w_en = 1'b1; i_err_clr = 1'b1; tick(); i_w_en = 1'b0; i_err_clr = 1'b0;
    check("ovf_set_beats_clr", o_overflow, 1);
    i_err_clr = 1'b1; tick(); i_err_clr = 1'b0;

    // Read and write in the same cycle while full: the write is still refused.
    i_w_en = 1'b1; i_w_data = mk_entry(32'hFFFF_0000);
    i_r_inc_en = 1'b1; i_r_inc_value = INC_W'(5);
    tick();
    i_w_en = 1'b0; i_r_inc_en = 1'b0; i_r_inc_value = '0;
    check("rw_full_ovf", o_overflow, 1);
    check("rw_full_r_ptr", o_r_ptr, 12);
    check("rw_full_free", o_full, 0);
    check("rw_full_cr", o_cr_data, 10);
    i_err_clr = 1'b1; tick(); i_err_clr = 1'b0;
    check("rw_full_commit_kept", o_w_ptr, 263);

    // Advance to address 254 and read the window wrapping past address 0.
    for (int i = 0; i < 48; i++) rd(5);
    rd(2);
    check("wrap_r_ptr", o_r_ptr, 254);
    i_r_dw_offset = 3'd3;
    #1;
    for (int k = 0; k < BE * LANES; k++)
      check($sformatf("wrap_off3_dw%0d", k), beat_dw(k), 32'(k + 3));
    i_r_dw_offset = '0;
    #1;
    check("wrap_off0_first", beat_dw(0), 0);
    check("wrap_off0_last", beat_dw(31), 31);

    // Reset in the middle of a TLP.
    wr(mk_entry(32'h1234_0000), 1'b0, 1'b0);
    i_n_rst = 1'b0;
    #2;
    check("mid_rst_r_ptr", o_r_ptr, 0);
    check("mid_rst_w_ptr", o_w_ptr, 0);
    check("mid_rst_empty", o_empty, 1);
    check("mid_rst_full", o_full, 0);
    tick();
    i_n_rst = 1'b1;
    tick();
    check("post_rst_used", o_used, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
